fifo_link_tx: RTL and testbench

Drain side of a router input/output FIFO. It pops flits from a show-ahead FIFO, frames them into packets using the length field in each head flit, and drives them onto a credit-flow-controlled NoC link toward the downstream router. Sits between a `fifo_improved` instance (its `read`/`empty`/`dataOut` ports) and the link wires of the neighbouring router.

---
 rtl/fifo_link_tx.sv | 143 ++++++++++++++
 tb/tb_fifo_link_tx.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_link_tx.sv
// fifo_link_tx: drains a show-ahead FIFO, frames packets from the head-flit
// length field and drives them onto a credit-flow-controlled NoC link.
module fifo_link_tx #(
    parameter int WIDTH   = 16,
    parameter int LENW    = 4,
    parameter int CREDITS = 4,
    parameter int CWIDTH  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty,
    input  logic [WIDTH-1:0]  fifo_data,
    output logic              fifo_read,
    input  logic              credit_in,
    output logic              link_valid,
    output logic [WIDTH-1:0]  link_data,
    output logic              link_head,
    output logic              link_tail,
    output logic              pkt_done,
    output logic [CWIDTH-1:0] credits,
    output logic              busy,
    output logic              cred_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BODY = 1'b1
    } state_t;

    localparam logic [CWIDTH-1:0] CMAX = CWIDTH'(CREDITS);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [LENW-1:0]   r_remain;
    logic [LENW-1:0]   w_remain_nxt;
    logic [CWIDTH-1:0] r_credits;
    logic [CWIDTH-1:0] w_credits_nxt;
    logic              r_cred_err;
    logic              w_ovf;
    logic              w_send;
    logic              w_head;
    logic              w_tail;
    logic [LENW-1:0]   w_len;

    logic              r_valid;
    logic [WIDTH-1:0]  r_data;
    logic              r_head;
    logic              r_tail;

    // Held low in reset so the FIFO is never popped while we are cleared
    assign w_send    = reset & ~fifo_empty & (r_credits != '0);
    assign fifo_read = w_send;
    assign w_len     = fifo_data[LENW-1:0];

    always_comb begin
        w_state_nxt  = r_state;
        w_remain_nxt = r_remain;
        w_head       = 1'b0;
        w_tail       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_send) begin
                    w_head = 1'b1;
                    if (w_len == '0) begin
                        w_tail = 1'b1;
                    end else begin
                        w_remain_nxt = w_len;
                        w_state_nxt  = S_BODY;
                    end
                end
            end
            S_BODY: begin
                if (w_send) begin
                    w_remain_nxt = r_remain - LENW'(1);
                    if (r_remain == LENW'(1)) begin
                        w_tail      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Credit bookkeeping; a return with the counter full is an overflow
    always_comb begin
        w_credits_nxt = r_credits;
        w_ovf         = 1'b0;
        unique case ({w_send, credit_in})
            2'b10: w_credits_nxt = r_credits - CWIDTH'(1);
            2'b01: begin
                if (r_credits == CMAX) begin
                    w_ovf = 1'b1;
                end else begin
                    w_credits_nxt = r_credits + CWIDTH'(1);
                end
            end
            default: w_credits_nxt = r_credits;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_remain   <= '0;
            r_credits  <= CMAX;
            r_cred_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_remain   <= w_remain_nxt;
            r_credits  <= w_credits_nxt;
            r_cred_err <= r_cred_err | w_ovf;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
        end else begin
            r_valid <= w_send;
            r_head  <= w_send & w_head;
            r_tail  <= w_send & w_tail;
            if (w_send) begin
                r_data <= fifo_data;
            end
        end
    end

    assign link_valid = r_valid;
    assign link_data  = r_data;
    assign link_head  = r_head;
    assign link_tail  = r_tail;
    assign pkt_done   = r_tail;
    assign credits    = r_credits;
    assign busy       = (r_state == S_BODY);
    assign cred_err   = r_cred_err;

endmodule

// File: tb/tb_fifo_link_tx.sv
// tb_fifo_link_tx: queue-backed FIFO model, credit return model and
// scoreboard for the fifo_link_tx link transmitter.
module tb_fifo_link_tx;

    localparam int WIDTH   = 16;
    localparam int LENW    = 4;
    localparam int CREDITS = 4;
    localparam int CWIDTH  = 3;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             h;
        logic             t;
    } flit_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              fifo_empty = 1'b1;
    logic [WIDTH-1:0]  fifo_data = '0;
    logic              fifo_read;
    logic              credit_in = 1'b0;
    logic              link_valid;
    logic [WIDTH-1:0]  link_data;
    logic              link_head;
    logic              link_tail;
    logic              pkt_done;
    logic [CWIDTH-1:0] credits;
    logic              busy;
    logic              cred_err;

    always #5 clk = ~clk;

    fifo_link_tx #(
        .WIDTH(WIDTH), .LENW(LENW), .CREDITS(CREDITS), .CWIDTH(CWIDTH)
    ) dut (
        .clk(clk), .reset(reset),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_read(fifo_read), .credit_in(credit_in),
        .link_valid(link_valid), .link_data(link_data),
        .link_head(link_head), .link_tail(link_tail),
        .pkt_done(pkt_done), .credits(credits),
        .busy(busy), .cred_err(cred_err)
    );

    int    checks = 0;
    int    errors = 0;
    int    n_sent = 0;
    flit_t q[$];
    flit_t sb[$];
    bit    gap = 0;
    bit    auto_cr = 1;
    bit    man = 0;
    bit    rd_s = 0;
    logic [3:0] ret = '0;
    int    exp_cred = CREDITS;
    bit    exp_err = 0;
    bit    exp_busy = 0;
    bit    exp_valid = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     nm, got, exp, $time);
        end
    endtask

    task automatic upd_fifo();
        fifo_empty = (q.size() == 0) || gap;
        fifo_data  = (q.size() != 0) ? q[0].d : '0;
    endtask

    // FIFO pop and credit return, applied just after each rising edge
    always @(posedge clk) begin
        #1;
        if (rd_s && q.size() != 0) void'(q.pop_front());
        credit_in = ret[0] | man;
        man = 0;
        ret = ret >> 1;
        upd_fifo();
    end

    // Monitor and reference model, evaluated mid-cycle
    always @(negedge clk) begin
        bit    s;
        flit_t e;
        if (!reset) begin
            chk("rst_fifo_read", 32'(fifo_read), 0);
            chk("rst_outs", {26'd0, link_valid, link_head, link_tail,
                             pkt_done, busy, cred_err}, 0);
            chk("rst_data", 32'(link_data), 0);
            chk("rst_credits", 32'(credits), CREDITS);
            exp_cred  = CREDITS;
            exp_err   = 0;
            exp_busy  = 0;
            exp_valid = 0;
            rd_s      = 0;
        end else begin
            chk("credits", 32'(credits), exp_cred);
            chk("cred_err", 32'(cred_err), 32'(exp_err));
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("link_valid", 32'(link_valid), 32'(exp_valid));
            if (link_valid) begin
                n_sent++;
                if (auto_cr) ret[1] = 1'b1;
                if (sb.size() == 0) begin
                    chk("sb_underrun", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("link_data", 32'(link_data), 32'(e.d));
                    chk("link_head", 32'(link_head), 32'(e.h));
                    chk("link_tail", 32'(link_tail), 32'(e.t));
                    chk("pkt_done", 32'(pkt_done), 32'(e.t));
                end
            end else begin
                chk("idle_flags", {29'd0, link_head, link_tail, pkt_done}, 0);
            end
            s = (q.size() != 0) && !gap && (exp_cred != 0);
            chk("fifo_read", 32'(fifo_read), 32'(s));
            rd_s = fifo_read;
            if (s) begin
                if (q[0].t) exp_busy = 0;
                else if (q[0].h) exp_busy = 1;
            end
            if (s && !credit_in) begin
                exp_cred--;
            end else if (!s && credit_in) begin
                if (exp_cred == CREDITS) exp_err = 1;
                else exp_cred++;
            end
            exp_valid = s;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_flit(input logic [WIDTH-1:0] d, input bit h,
                             input bit t);
        flit_t f;
        f.d = d;
        f.h = h;
        f.t = t;
        q.push_back(f);
        sb.push_back(f);
        upd_fifo();
    endtask

    task automatic push_pkt(input logic [WIDTH-1:0] hd);
        int l;
        l = int'(hd[LENW-1:0]);
        push_flit(hd, 1'b1, l == 0);
        for (int i = 1; i <= l; i++) push_flit(16'($urandom), 1'b0, i == l);
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while ((q.size() != 0 || sb.size() != 0) && k < 600) begin
            cyc(1);
            k++;
        end
        chk({nm, "_timeout"}, 32'(k >= 600), 0);
        cyc(6);
    endtask

    function automatic logic [WIDTH-1:0] hd_len(input int l);
        logic [WIDTH-1:0] r;
        r = 16'($urandom);
        r[LENW-1:0] = LENW'(l);
        return r;
    endfunction

    initial begin
        int base;
        int k;
        cyc(3);
        reset = 1'b1;
        cyc(2);

        push_flit(16'h1230, 1'b1, 1'b1);
        cyc(1);
        chk("single_flags", {28'd0, link_valid, link_head, link_tail,
                             pkt_done}, 32'hf);
        chk("single_data", 32'(link_data), 32'h1230);
        chk("single_cred3", 32'(credits), 3);
        drain("single");
        chk("single_cred_back", 32'(credits), CREDITS);

        base = n_sent;
        push_pkt(16'hA003);
        drain("multi");
        chk("multi_count", n_sent - base, 4);
        chk("multi_cred_back", 32'(credits), CREDITS);

        auto_cr = 0;
        base = n_sent;
        for (int i = 0; i < 8; i++) push_pkt(hd_len(0));
        cyc(15);
        chk("starve_sent", n_sent - base, 4);
        chk("starve_cred0", 32'(credits), 0);
        man = 1;
        cyc(5);
        chk("starve_one_more", n_sent - base, 5);
        chk("starve_cred0b", 32'(credits), 0);
        for (int i = 0; i < 7; i++) begin
            man = 1;
            cyc(2);
        end
        cyc(4);
        chk("starve_all", n_sent - base, 8);
        chk("starve_cred_full", 32'(credits), CREDITS);
        auto_cr = 1;

        base = n_sent;
        push_flit(hd_len(2), 1'b1, 1'b0);
        push_flit(16'($urandom), 1'b0, 1'b0);
        cyc(3);
        chk("gap_busy", 32'(busy), 1);
        chk("gap_novalid", 32'(link_valid), 0);
        cyc(2);
        push_flit(16'hBEEF, 1'b0, 1'b1);
        drain("gap");
        chk("gap_count", n_sent - base, 3);

        auto_cr = 0;
        cyc(2);
        man = 1;
        cyc(4);
        chk("ovf_err", 32'(cred_err), 1);
        chk("ovf_cred", 32'(credits), CREDITS);
        cyc(3);
        chk("ovf_sticky", 32'(cred_err), 1);
        auto_cr = 1;

        for (int i = 0; i < 40; i++) begin
            push_pkt(hd_len(int'($urandom_range(0, 15))));
            cyc(int'($urandom_range(0, 6)));
            if ($urandom_range(0, 2) == 0) begin
                gap = 1;
                upd_fifo();
                cyc(int'($urandom_range(1, 4)));
                gap = 0;
                upd_fifo();
            end
        end
        drain("random");

        base = n_sent;
        push_pkt(hd_len(3));
        k = 0;
        while (n_sent == base && k < 50) begin
            cyc(1);
            k++;
        end
        chk("rst_head_timeout", 32'(k >= 50), 0);
        #1;
        reset = 1'b0;
        q.delete();
        sb.delete();
        ret = '0;
        man = 0;
        gap = 0;
        rd_s = 0;
        upd_fifo();
        #1;
        chk("async_rst_outs", {26'd0, link_valid, link_head, link_tail,
                               pkt_done, busy, cred_err}, 0);
        chk("async_rst_cred", 32'(credits), CREDITS);
        chk("async_rst_data", 32'(link_data), 0);
        cyc(2);
        reset = 1'b1;
        cyc(1);
        base = n_sent;
        push_pkt(hd_len(1));
        drain("post_rst");
        chk("post_rst_count", n_sent - base, 2);
        chk("post_rst_err", 32'(cred_err), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
